noc_pe_rx_checker: RTL

Per-PE receive-side traffic sink and checker for the openNocTop mesh; the counterpart of the random traffic generator that injects packets. It consumes every flit the NoC writes to its PE port, checks destination address and per-source ordering, and measures latency. It exports receive/error/latency statistics and a done flag for the bench aggregator.
- NoC-to-PE write port has no ready, so the block must accept a flit on every cycle.

---
 rtl/noc_pe_rx_checker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/noc_pe_rx_checker.sv
// Receive-side sink/checker for one mesh PE: dest and per-source sequence checks, latency stats.
// Optional LAT_HIST_EN adds a 16-bucket latency histogram on port lat_hist.
module noc_pe_rx_checker #(
  parameter int X          = 10,
  parameter int Y          = 10,
  parameter int data_width = 256,
  parameter int x_size     = $clog2(X),
  parameter int y_size     = $clog2(Y),
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int EXPECTED   = 1000,
  parameter int SEQ_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  w_valid_pe,
  input  logic [x_size+y_size+data_width-1:0]   w_data_pe,
  output logic [31:0]                           receive_count,
  output logic [15:0]                           err_count,
  output logic [47:0]                           lat_sum,
  output logic [31:0]                           lat_max,
  output logic [31:0]                           lat_min,
  output logic                                  done,
  output logic [31:0]                           cycle_now,
  output logic [1:0]                            state_dbg
`ifdef LAT_HIST_EN
  ,
  output logic [16*32-1:0]                      lat_hist
`endif
);

  localparam int NSRC  = X * Y;
  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int HDR_W = x_size + y_size;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  state_e state_q, state_d;

  logic [31:0] cycle_q, rx_cnt_q, lat_max_q, lat_min_q;
  logic [15:0] err_cnt_q;
  logic [47:0] lat_sum_q;
  logic [SEQ_W-1:0] seq_tab_q [NSRC];

  // Flit field decode (NoC write port has no ready: every flit is taken)
  logic [data_width-1:0] pay;
  logic [x_size-1:0]     in_dx;
  logic [y_size-1:0]     in_dy;
  logic [31:0]           in_ts;
  logic [15:0]           in_src;
  logic [SEQ_W-1:0]      in_seq;
  logic                  unused_pay;

  assign pay        = w_data_pe[HDR_W +: data_width];
  assign in_dx      = w_data_pe[x_size-1:0];
  assign in_dy      = w_data_pe[x_size +: y_size];
  assign in_ts      = pay[31:0];
  assign in_src     = pay[47:32];
  assign in_seq     = pay[48 +: SEQ_W];
  assign unused_pay = ^pay[data_width-1:48+SEQ_W];

  // S1 stage
  logic             s1_valid_q, s1_dest_err_q;
  logic [15:0]      s1_src_q;
  logic [SEQ_W-1:0] s1_seq_q;
  logic [31:0]      s1_lat_q;

  // S2: the table is read combinationally and written on the same edge, so a
  // back-to-back flit from the same source always sees the freshly written entry.
  logic             src_ok, seq_err, overrun, flit_err;
  logic [IDX_W-1:0] idx;
  logic [SEQ_W-1:0] tab_rd;

  assign src_ok   = s1_src_q < 16'(NSRC);
  assign idx      = s1_src_q[IDX_W-1:0];
  assign tab_rd   = seq_tab_q[idx];
  assign seq_err  = src_ok && (s1_seq_q != tab_rd);
  assign overrun  = (state_q == DONE) || (rx_cnt_q == 32'(EXPECTED));
  assign flit_err = s1_dest_err_q || !src_ok || seq_err || overrun;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (!start)                           state_d = IDLE;
        else if (rx_cnt_q == 32'(EXPECTED))   state_d = DONE;
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cycle_q       <= '0;
      s1_valid_q    <= 1'b0;
      s1_dest_err_q <= 1'b0;
      s1_src_q      <= '0;
      s1_seq_q      <= '0;
      s1_lat_q      <= '0;
      rx_cnt_q      <= '0;
      err_cnt_q     <= '0;
      lat_sum_q     <= '0;
      lat_max_q     <= '0;
      lat_min_q     <= 32'hFFFF_FFFF;
      for (int i = 0; i < NSRC; i++) seq_tab_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_q + 32'd1;
      s1_valid_q    <= w_valid_pe && (state_q != IDLE);
      s1_dest_err_q <= (in_dx != x_size'(MY_X)) || (in_dy != y_size'(MY_Y));
      s1_src_q      <= in_src;
      s1_seq_q      <= in_seq;
      s1_lat_q      <= cycle_q - in_ts;
      if (s1_valid_q) begin
        rx_cnt_q  <= rx_cnt_q + 32'd1;
        if (flit_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        lat_sum_q <= lat_sum_q + {16'd0, s1_lat_q};
        if (s1_lat_q > lat_max_q) lat_max_q <= s1_lat_q;
        if (s1_lat_q < lat_min_q) lat_min_q <= s1_lat_q;
        // Match and resync both leave the entry at seq+1
        if (src_ok) seq_tab_q[idx] <= s1_seq_q + SEQ_W'(1);
      end
    end
  end

`ifdef LAT_HIST_EN
  logic [31:0] hist_q [16];
  logic [3:0]  bucket;

  assign bucket = (|s1_lat_q[31:7]) ? 4'hF : s1_lat_q[6:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) hist_q[i] <= '0;
    end else if (s1_valid_q && hist_q[bucket] != 32'hFFFF_FFFF) begin
      hist_q[bucket] <= hist_q[bucket] + 32'd1;
    end
  end

  always_comb begin
    lat_hist = '0;
    for (int i = 0; i < 16; i++) lat_hist[i*32 +: 32] = hist_q[i];
  end
`endif

  assign receive_count = rx_cnt_q;
  assign err_count     = err_cnt_q;
  assign lat_sum       = lat_sum_q;
  assign lat_max       = lat_max_q;
  assign lat_min       = lat_min_q;
  assign done          = (state_q == DONE);
  assign cycle_now     = cycle_q;
  assign state_dbg     = state_q;

endmodule
